// File: rtl/hc4_run_ctrl.sv
// hc4_run_ctrl: run-control sequencer for the hc4 core.
// Owns the core reset and clock enable, streams the program ROM image in
// from the host, and steps the core through hold/halt/run/step with a PC
// breakpoint.
// Optional build macro: HC4_RUNCTL_WDOG_EN adds a stall watchdog in RUN
// that halts the core with halt_cause=3.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RSTH  | core held in reset for RST_HOLD cycles, then HALT
// HALT  | core stopped, host commands accepted
// LOAD  | core in reset, ROM bytes written at 0..end address
// RUN   | core clocked until breakpoint, watchdog or command
// STEP  | core clocked for cmd_arg+1 cycles, then HALT
module hc4_run_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int RST_HOLD = 4,
  parameter int WDOG_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        cmd,
  input  logic [ADDR_W-1:0] cmd_arg,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [DATA_W-1:0] rom_wdata,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  output logic              cpu_nReset,
  output logic              cpu_clk_en,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic              cmd_err
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int CNT_W  = (ADDR_W > HOLD_W) ? ADDR_W : HOLD_W;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_LOAD = 3'd1;
  localparam logic [2:0] CMD_RUN  = 3'd2;
  localparam logic [2:0] CMD_HALT = 3'd3;
  localparam logic [2:0] CMD_STEP = 3'd4;
  localparam logic [2:0] CMD_RST  = 3'd5;

  localparam logic [1:0] CAUSE_CMD  = 2'd0;
  localparam logic [1:0] CAUSE_BP   = 2'd1;
  localparam logic [1:0] CAUSE_STEP = 2'd2;
  localparam logic [1:0] CAUSE_WDOG = 2'd3;

  typedef enum logic [2:0] {
    ST_RSTH = 3'd0,
    ST_HALT = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] end_addr;
  logic              first_cyc;

  logic run_like;
  logic bp_hit;
  logic wdog_hit;
  logic cmd_rst;
  logic cmd_halt;
  logic cmd_rej;

  assign run_like = (state == ST_RUN) || (state == ST_STEP);

  // First cycle after leaving HALT masks the breakpoint so a resume advances.
  assign bp_hit = run_like && !first_cyc && bp_en && (pc_in == bp_addr);

  // Command decode used while the core is running or stepping.
  always_comb begin
    cmd_rst  = cmd_valid && (cmd == CMD_RST);
    cmd_halt = cmd_valid && (cmd == CMD_HALT);
    cmd_rej  = cmd_valid && (cmd != CMD_NOP) && (cmd != CMD_HALT) && (cmd != CMD_RST);
  end

  // Handshake and core-control outputs decoded from the state register.
  always_comb begin
    cmd_ready  = (state == ST_HALT) || run_like;
    ld_ready   = (state == ST_LOAD);
    halted     = (state == ST_HALT);
    cpu_nReset = (state != ST_RSTH) && (state != ST_LOAD);
    cpu_clk_en = run_like && !bp_hit && !wdog_hit;
  end

`ifdef HC4_RUNCTL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  logic [WDOG_W-1:0] stall_cnt;
  logic [ADDR_W-1:0] pc_prev;

  // Count RUN cycles with an unchanged pc_in; anything else clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      pc_prev   <= '0;
    end else begin
      pc_prev <= pc_in;
      if ((state != ST_RUN) || (pc_in != pc_prev)) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + WDOG_W'(1);
      end
    end
  end

  assign wdog_hit = (state == ST_RUN) && (stall_cnt == WDOG_W'(WDOG_CYC - 1));
`else
  logic [31:0] unused_wdog_cyc;
  assign unused_wdog_cyc = WDOG_CYC;
  assign wdog_hit        = 1'b0;
`endif

  // Main sequencer: state, hold/step down-counter, ROM write port, status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RSTH;
      cnt        <= CNT_W'(RST_HOLD - 1);
      addr       <= '0;
      end_addr   <= '0;
      first_cyc  <= 1'b0;
      rom_we     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= '0;
      halt_cause <= CAUSE_CMD;
      cmd_err    <= 1'b0;
    end else begin
      rom_we    <= 1'b0;
      cmd_err   <= 1'b0;
      first_cyc <= 1'b0;
      case (state)
        ST_RSTH: begin
          if (cnt == '0) begin
            state      <= ST_HALT;
            halt_cause <= CAUSE_CMD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HALT: begin
          if (cmd_valid) begin
            case (cmd)
              CMD_LOAD: begin
                end_addr <= cmd_arg;
                addr     <= '0;
                state    <= ST_LOAD;
              end
              CMD_RUN: begin
                first_cyc <= 1'b1;
                state     <= ST_RUN;
              end
              CMD_STEP: begin
                cnt       <= CNT_W'(cmd_arg);
                first_cyc <= 1'b1;
                state     <= ST_STEP;
              end
              CMD_RST: begin
                cnt   <= CNT_W'(RST_HOLD - 1);
                state <= ST_RSTH;
              end
              CMD_NOP, CMD_HALT: ;
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            rom_we    <= 1'b1;
            rom_waddr <= addr;
            rom_wdata <= ld_data;
            // Final beat: no increment, so an end address of all-ones never wraps.
            if (addr == end_addr) begin
              cnt   <= CNT_W'(RST_HOLD - 1);
              state <= ST_RSTH;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        ST_RUN, ST_STEP: begin
          if (cmd_rej) begin
            cmd_err <= 1'b1;
          end
          if (cmd_rst) begin
            cnt   <= CNT_W'(RST_HOLD - 1);
            state <= ST_RSTH;
          end else if (bp_hit) begin
            halt_cause <= CAUSE_BP;
            state      <= ST_HALT;
          end else if (wdog_hit) begin
            halt_cause <= CAUSE_WDOG;
            state      <= ST_HALT;
          end else if (cmd_halt) begin
            halt_cause <= CAUSE_CMD;
            state      <= ST_HALT;
          end else if (state == ST_STEP) begin
            if (cnt == '0) begin
              halt_cause <= CAUSE_STEP;
              state      <= ST_HALT;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          cnt   <= CNT_W'(RST_HOLD - 1);
          state <= ST_RSTH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc4_run_ctrl.sv
// Directed bench for hc4_run_ctrl: reset hold, ROM load, step, breakpoint,
// command handling, full-size load, mid-load reset and the stall watchdog.
module tb_hc4_run_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        cmd;
  logic [ADDR_W-1:0] cmd_arg;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic              ld_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [DATA_W-1:0] rom_wdata;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] bp_addr;
  logic              bp_en;
  logic              cpu_nReset;
  logic              cpu_clk_en;
  logic              halted;
  logic [1:0]        halt_cause;
  logic              cmd_err;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  hc4_run_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RST_HOLD(4),
    .WDOG_CYC(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_arg   (cmd_arg),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .pc_in     (pc_in),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .cpu_nReset(cpu_nReset),
    .cpu_clk_en(cpu_clk_en),
    .halted    (halted),
    .halt_cause(halt_cause),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [ADDR_W-1:0] a);
    cmd       = c;
    cmd_arg   = a;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  logic [7:0] ld_bytes [4];
  int         n_we;

  initial begin
    ld_bytes  = '{8'hA0, 8'hB1, 8'hC2, 8'hE0};
    reset     = 1'b1;
    cmd       = 3'd0;
    cmd_arg   = '0;
    cmd_valid = 1'b0;
    ld_data   = '0;
    ld_valid  = 1'b0;
    pc_in     = '0;
    bp_addr   = '0;
    bp_en     = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_nreset", cpu_nReset, 0);
    chk("rst_clken", cpu_clk_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_waddr", rom_waddr, 0);
    chk("rst_wdata", rom_wdata, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_cmd_err", cmd_err, 0);

    // Reset hold: 4 cycles of cpu_nReset=0 after release
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_nreset", cpu_nReset, 0);
      chk("hold_clken", cpu_clk_en, 0);
      chk("hold_halted", halted, 0);
      cyc();
    end
    chk("hold_done_nreset", cpu_nReset, 1);
    chk("hold_done_halted", halted, 1);
    chk("hold_done_cause", halt_cause, 0);
    chk("hold_done_cmd_ready", cmd_ready, 1);
    chk("hold_done_clken", cpu_clk_en, 0);

    // LOAD end address 3 with gaps on ld_valid
    issue(3'd1, 12'h003);
    chk("load_ld_ready", ld_ready, 1);
    chk("load_cmd_ready", cmd_ready, 0);
    chk("load_nreset", cpu_nReset, 0);
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b0;
      cyc();
      chk("load_gap_we", rom_we, 0);
      ld_valid = 1'b1;
      ld_data  = ld_bytes[k];
      cyc();
      ld_valid = 1'b0;
      chk("load_we", rom_we, 1);
      chk("load_waddr", rom_waddr, k);
      chk("load_wdata", rom_wdata, ld_bytes[k]);
    end
    chk("load_end_ld_ready", ld_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("reload_hold_nreset", cpu_nReset, 0);
      cyc();
    end
    chk("reload_we_idle", rom_we, 0);
    chk("reload_halted", halted, 1);
    chk("reload_nreset", cpu_nReset, 1);

    // STEP arg=2 with a rejected RUN in the middle
    issue(3'd4, 12'd2);
    chk("step_c0_clken", cpu_clk_en, 1);
    chk("step_c0_halted", halted, 0);
    issue(3'd2, 12'd0);
    chk("step_c1_err", cmd_err, 1);
    chk("step_c1_clken", cpu_clk_en, 1);
    cyc();
    chk("step_c2_clken", cpu_clk_en, 1);
    chk("step_c2_err", cmd_err, 0);
    cyc();
    chk("step_done_clken", cpu_clk_en, 0);
    chk("step_done_halted", halted, 1);
    chk("step_done_cause", halt_cause, 2);

    // RUN into breakpoint at 0x005
    bp_en   = 1'b1;
    bp_addr = 12'h005;
    pc_in   = '0;
    issue(3'd2, 12'd0);
    for (int k = 0; k < 6; k++) begin
      pc_in = ADDR_W'(k);
      #1;
      chk("bp_run_clken", cpu_clk_en, (k != 5));
      cyc();
    end
    chk("bp_halted", halted, 1);
    chk("bp_cause", halt_cause, 1);

    // Resume from the breakpoint address advances
    issue(3'd2, 12'd0);
    chk("resume_clken", cpu_clk_en, 1);
    cyc();
    chk("resume_running", halted, 0);
    pc_in = 12'h006;
    #1;
    chk("resume_pc6_clken", cpu_clk_en, 1);
    cyc();
    chk("resume_pc6_running", halted, 0);

    // Breakpoint and HALT command in the same cycle
    bp_addr   = 12'h008;
    pc_in     = 12'h008;
    cmd       = 3'd3;
    cmd_valid = 1'b1;
    #1;
    chk("bp_and_halt_clken", cpu_clk_en, 0);
    cyc();
    cmd_valid = 1'b0;
    chk("bp_and_halt_halted", halted, 1);
    chk("bp_and_halt_cause", halt_cause, 1);

    // Plain HALT command in RUN
    bp_en = 1'b0;
    issue(3'd2, 12'd0);
    cmd       = 3'd3;
    cmd_valid = 1'b1;
    #1;
    chk("halt_accept_clken", cpu_clk_en, 1);
    cyc();
    cmd_valid = 1'b0;
    chk("halt_cmd_halted", halted, 1);
    chk("halt_cmd_cause", halt_cause, 0);

    // Illegal command in HALT
    issue(3'd7, 12'd0);
    chk("illegal_err", cmd_err, 1);
    chk("illegal_halted", halted, 1);
    cyc();
    chk("illegal_err_pulse", cmd_err, 0);

    // RESET_CPU from HALT
    issue(3'd5, 12'd0);
    chk("rstcpu_nreset", cpu_nReset, 0);
    chk("rstcpu_halted", halted, 0);
    repeat (4) cyc();
    chk("rstcpu_done_halted", halted, 1);

    // Full 4096-byte load, no wrap
    issue(3'd1, 12'hFFF);
    ld_valid = 1'b1;
    n_we = 0;
    for (int i = 0; i < 4096; i++) begin
      ld_data = i[7:0];
      cyc();
      if (rom_we === 1'b1 && rom_waddr === ADDR_W'(i) && rom_wdata === i[7:0]) n_we++;
    end
    chk("full_load_beats", n_we, 4096);
    chk("full_load_last_addr", rom_waddr, 12'hFFF);
    chk("full_load_ld_ready", ld_ready, 0);
    cyc();
    chk("full_load_no_wrap_we", rom_we, 0);
    ld_valid = 1'b0;
    repeat (3) cyc();
    chk("full_load_halted", halted, 1);

    // Reset in the middle of a LOAD
    issue(3'd1, 12'hFFF);
    ld_valid = 1'b1;
    ld_data  = 8'h5A;
    cyc();
    cyc();
    chk("midload_we", rom_we, 1);
    chk("midload_waddr", rom_waddr, 1);
    reset = 1'b1;
    cyc();
    chk("midload_rst_we", rom_we, 0);
    chk("midload_rst_ld_ready", ld_ready, 0);
    chk("midload_rst_nreset", cpu_nReset, 0);
    chk("midload_rst_waddr", rom_waddr, 0);
    reset = 1'b0;
    cyc();
    chk("midload_after_we0", rom_we, 0);
    cyc();
    chk("midload_after_we1", rom_we, 0);
    ld_valid = 1'b0;
    cyc();
    cyc();
    chk("midload_halted", halted, 1);

`ifdef HC4_RUNCTL_WDOG_EN
    // Watchdog: pc stuck at 0x010 halts after 8 RUN cycles
    pc_in = 12'h010;
    issue(3'd2, 12'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("wdog_clken", cpu_clk_en, (k != 7));
      cyc();
    end
    chk("wdog_halted", halted, 1);
    chk("wdog_cause", halt_cause, 3);
`else
    // Without the watchdog a stuck pc keeps running
    pc_in = 12'h010;
    issue(3'd2, 12'd0);
    repeat (20) cyc();
    chk("nowdog_running", halted, 0);
    chk("nowdog_clken", cpu_clk_en, 1);
    issue(3'd3, 12'd0);
    chk("nowdog_halted", halted, 1);
    chk("nowdog_cause", halt_cause, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
